mmc1_bank_ctrl: RTL and testbench

//  MMC1 (mapper 001) configuration controller. It decodes CPU writes to $8000-$FFFF

---
 rtl/mmc1_bank_ctrl.sv | 122 ++++++++++++
 tb/tb_mmc1_bank_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mmc1_bank_ctrl.sv
// MMC1 (mapper 001) configuration controller: 5-bit serial register load port
// plus combinational PRG/CHR bank, mirroring and PRG-RAM enable decode.
module mmc1_bank_ctrl #(
   parameter int PRG_ROM_DEPTH = 17,
   parameter int CHR_ROM_DEPTH = 13,
   parameter int PRG_RAM       = 0
) (
   input  logic                      i_clk_cpu,
   input  logic                      i_rst,
   input  logic                      i_m2,
   input  logic [14:0]               i_cpu_addr,
   input  logic [7:0]                i_cpu_data,
   input  logic                      i_cpu_rw,
   input  logic                      i_romsel,
   input  logic [13:0]               i_ppu_addr,
   output logic [PRG_ROM_DEPTH-15:0] o_prg_bank,
   output logic [CHR_ROM_DEPTH-13:0] o_chr_bank,
   output logic                      o_ciram_a10,
   output logic                      o_prg_ram_en,
   output logic [4:0]                o_ctrl_q
);

   localparam int PB  = PRG_ROM_DEPTH - 14;
   localparam int CB  = CHR_ROM_DEPTH - 12;
   localparam int PBN = (PB < 4) ? PB : 4;
   localparam int CBN = (CB < 5) ? CB : 5;

   localparam logic [2:0] CNT_LAST   = 3'd4;
   localparam logic [4:0] CTRL_RESET = 5'b01100;

   logic [4:0] r_sr;
   logic [2:0] r_cnt;
   logic [4:0] r_ctrl;
   logic [4:0] r_chr0;
   logic [4:0] r_chr1;
   logic [4:0] r_prg;
   logic       r_wr_prev;

   logic          w_wr_cyc;
   logic          w_wr_acc;
   logic [4:0]    w_val;
   logic [PB-1:0] w_prg_sel;
   logic [CB-1:0] w_chr0_sel;
   logic [CB-1:0] w_chr1_sel;
   logic          w_unused;

   assign w_wr_cyc = i_romsel & ~i_cpu_rw & i_m2;
   // Only the first cycle of a write burst counts, so RMW double-writes are ignored.
   assign w_wr_acc = w_wr_cyc & ~r_wr_prev;
   assign w_val    = {i_cpu_data[0], r_sr[4:1]};

   always_ff @(posedge i_clk_cpu) begin
      if (i_rst) begin
         r_sr      <= '0;
         r_cnt     <= '0;
         r_ctrl    <= CTRL_RESET;
         r_chr0    <= '0;
         r_chr1    <= '0;
         r_prg     <= '0;
         r_wr_prev <= 1'b0;
      end else begin
         r_wr_prev <= w_wr_cyc;
         if (w_wr_acc) begin
            if (i_cpu_data[7]) begin
               r_sr   <= '0;
               r_cnt  <= '0;
               r_ctrl <= r_ctrl | CTRL_RESET;
            end else if (r_cnt == CNT_LAST) begin
               r_sr  <= '0;
               r_cnt <= '0;
               case (i_cpu_addr[14:13])
                  2'b00:   r_ctrl <= w_val;
                  2'b01:   r_chr0 <= w_val;
                  2'b10:   r_chr1 <= w_val;
                  default: r_prg  <= w_val;
               endcase
            end else begin
               r_sr  <= w_val;
               r_cnt <= r_cnt + 3'd1;
            end
         end
      end
   end

   // prg[4] never reaches the bank; narrow fields keep their LSBs.
   assign w_prg_sel  = PB'(r_prg[PBN-1:0]);
   assign w_chr0_sel = CB'(r_chr0[CBN-1:0]);
   assign w_chr1_sel = CB'(r_chr1[CBN-1:0]);

   always_comb begin
      o_prg_bank = w_prg_sel;
      case (r_ctrl[3:2])
         2'b00, 2'b01: o_prg_bank[0] = i_cpu_addr[14];
         2'b10:        o_prg_bank = i_cpu_addr[14] ? w_prg_sel : '0;
         default:      o_prg_bank = i_cpu_addr[14] ? '1 : w_prg_sel;
      endcase
   end

   always_comb begin
      o_chr_bank = w_chr0_sel;
      if (r_ctrl[4]) begin
         o_chr_bank = i_ppu_addr[12] ? w_chr1_sel : w_chr0_sel;
      end else begin
         o_chr_bank[0] = i_ppu_addr[12];
      end
   end

   always_comb begin
      case (r_ctrl[1:0])
         2'b00:   o_ciram_a10 = 1'b0;
         2'b01:   o_ciram_a10 = 1'b1;
         2'b10:   o_ciram_a10 = i_ppu_addr[10];
         default: o_ciram_a10 = i_ppu_addr[11];
      endcase
   end

   assign o_prg_ram_en = (PRG_RAM != 0) & ~r_prg[4];
   assign o_ctrl_q     = r_ctrl;

   assign w_unused = ^{i_cpu_addr[12:0], i_ppu_addr, i_cpu_data[6:1], r_chr0, r_chr1, r_prg};

endmodule

// File: tb/tb_mmc1_bank_ctrl.sv
// Bench for mmc1_bank_ctrl: directed table/sequences plus random traffic
// compared against a queue-based register model.
module tb_mmc1_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst, m2, cpu_rw, romsel;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic [13:0] ppu_addr;
   logic [2:0]  prg_bank;
   logic [0:0]  chr_bank;
   logic        ciram_a10, prg_ram_en;
   logic [4:0]  ctrl_q;

   int errors = 0;
   int checks = 0;

   mmc1_bank_ctrl #(.PRG_ROM_DEPTH(17), .CHR_ROM_DEPTH(13), .PRG_RAM(1)) dut (
      .i_clk_cpu(clk), .i_rst(rst), .i_m2(m2), .i_cpu_addr(cpu_addr),
      .i_cpu_data(cpu_data), .i_cpu_rw(cpu_rw), .i_romsel(romsel),
      .i_ppu_addr(ppu_addr), .o_prg_bank(prg_bank), .o_chr_bank(chr_bank),
      .o_ciram_a10(ciram_a10), .o_prg_ram_en(prg_ram_en), .o_ctrl_q(ctrl_q)
   );

   always #5 clk = ~clk;

   // Register model: serial bits collected in a queue, committed on the fifth.
   int unsigned m_ctrl, m_chr0, m_chr1, m_prg;
   bit          m_prev;
   bit          m_q[$];

   always @(posedge clk) begin
      bit wr;
      int unsigned val;
      wr = romsel && !cpu_rw && m2;
      if (rst) begin
         m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0; m_prev = 0;
         m_q.delete();
      end else begin
         if (wr && !m_prev) begin
            if (cpu_data[7]) begin
               m_q.delete();
               m_ctrl = m_ctrl | 12;
            end else begin
               m_q.push_back(cpu_data[0]);
               if (m_q.size() == 5) begin
                  val = 0;
                  for (int i = 0; i < 5; i++) val += int'(m_q[i]) << i;
                  case (cpu_addr[14:13])
                     2'd0: m_ctrl = val;
                     2'd1: m_chr0 = val;
                     2'd2: m_chr1 = val;
                     default: m_prg = val;
                  endcase
                  m_q.delete();
               end
            end
         end
         m_prev = wr;
      end
   end

   function automatic int exp_prg(input int a14);
      int p, mode;
      p = m_prg % 16;
      mode = (m_ctrl / 4) % 4;
      if (mode < 2) return ((p / 2) * 2 + a14) % 8;
      if (mode == 2) return a14 ? p % 8 : 0;
      return a14 ? 7 : p % 8;
   endfunction

   function automatic int exp_chr(input int p12);
      if ((m_ctrl / 16) % 2 == 0) return ((m_chr0 / 2) * 2 + p12) % 2;
      return p12 ? m_chr1 % 2 : m_chr0 % 2;
   endfunction

   function automatic int exp_a10(input int p10, input int p11);
      case (m_ctrl % 4)
         0: return 0;
         1: return 1;
         2: return p10;
         default: return p11;
      endcase
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic idle();
      romsel = 1'b0; cpu_rw = 1'b1; m2 = 1'b0;
   endtask

   task automatic wr(input logic [14:0] a, input logic [7:0] d);
      @(negedge clk);
      romsel = 1'b1; cpu_rw = 1'b0; m2 = 1'b1; cpu_addr = a; cpu_data = d;
      @(negedge clk);
      idle();
   endtask

   task automatic wr5(input logic [14:0] a, input logic [4:0] v);
      for (int i = 0; i < 5; i++) wr(a, {7'd0, v[i]});
   endtask

   task automatic look(input logic [14:0] a, input logic [13:0] p);
      cpu_addr = a; ppu_addr = p; #1;
   endtask

   typedef struct {
      logic [14:0] ca;
      logic [13:0] pa;
      int          prg;
      int          chr;
      int          a10;
   } vec_t;

   vec_t tbl[4];

   initial begin
      tbl[0] = '{15'h4000, 14'h0000, 7, 0, 0};
      tbl[1] = '{15'h0000, 14'h0000, 0, 0, 0};
      tbl[2] = '{15'h7FFF, 14'h1000, 7, 1, 0};
      tbl[3] = '{15'h3FFF, 14'h0C00, 0, 0, 0};

      idle(); cpu_addr = '0; cpu_data = '0; ppu_addr = '0; rst = 1'b1;
      @(negedge clk); rst = 1'b0;

      // reset state
      chk("rst_ctrl", ctrl_q, 5'b01100);
      chk("rst_ram_en", prg_ram_en, 1);
      for (int i = 0; i < 4; i++) begin
         look(tbl[i].ca, tbl[i].pa);
         chk("rst_prg_bank", prg_bank, tbl[i].prg);
         chk("rst_chr_bank", chr_bank, tbl[i].chr);
         chk("rst_a10", ciram_a10, tbl[i].a10);
      end

      // five isolated writes to $E000
      wr5(15'h6000, 5'b00101);
      look(15'h0000, 14'h0); chk("prg_lo", prg_bank, 5);
      look(15'h4000, 14'h0); chk("prg_hi", prg_bank, 7);
      chk("ram_en_prg5", prg_ram_en, 1);

      // partial load dropped by d[7]
      for (int i = 0; i < 3; i++) wr(15'h2000, 8'h01);
      wr(15'h2000, 8'h80);
      wr5(15'h0000, 5'b11111);
      chk("ctrl_after_drop", ctrl_q, 31);
      look(15'h0, 14'h0800); chk("a10_h1", ciram_a10, 1);
      look(15'h0, 14'h0400); chk("a10_h0", ciram_a10, 0);
      look(15'h0, 14'h1000); chk("chr_4k", chr_bank, 0);

      // back-to-back writes: only the first counts
      @(negedge clk);
      romsel = 1'b1; cpu_rw = 1'b0; m2 = 1'b1; cpu_addr = 15'h0000; cpu_data = 8'h01;
      @(negedge clk); cpu_data = 8'h01;
      @(negedge clk); idle();
      wr(15'h0000, 8'h00); wr(15'h0000, 8'h00); wr(15'h0000, 8'h01);
      chk("b2b_no_commit", ctrl_q, 31);
      wr(15'h0000, 8'h00);
      chk("b2b_commit", ctrl_q, 5'b01001);

      // mirroring
      wr5(15'h0000, 5'b00010);
      look(15'h0, 14'h0400); chk("vert_a10_1", ciram_a10, 1);
      look(15'h0, 14'h0800); chk("vert_a10_0", ciram_a10, 0);
      wr5(15'h0000, 5'b00001);
      look(15'h0, 14'h0800); chk("one_a10_a", ciram_a10, 1);
      look(15'h0, 14'h0000); chk("one_a10_b", ciram_a10, 1);

      // reset during the 4th serial write
      for (int i = 0; i < 3; i++) wr(15'h6000, 8'h01);
      @(negedge clk);
      romsel = 1'b1; cpu_rw = 1'b0; m2 = 1'b1; cpu_addr = 15'h6000; cpu_data = 8'h01; rst = 1'b1;
      @(negedge clk); idle(); rst = 1'b0;
      chk("midrst_ctrl", ctrl_q, 5'b01100);
      look(15'h0000, 14'h0); chk("midrst_prg", prg_bank, 0);
      wr5(15'h6000, 5'b00110);
      look(15'h0000, 14'h0); chk("fresh_prg", prg_bank, 6);

      // prg[4] disables RAM; CHR 4K with chr1=1
      wr5(15'h6000, 5'b10000);
      chk("ram_dis", prg_ram_en, 0);
      look(15'h0000, 14'h0); chk("prg_bit4_bank", prg_bank, 0);
      wr5(15'h4000, 5'b00001);
      wr5(15'h0000, 5'b11100);
      look(15'h0, 14'h1000); chk("chr1_bank", chr_bank, 1);
      look(15'h0, 14'h0000); chk("chr0_bank", chr_bank, 0);

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         #1;
         chk("rnd_prg", prg_bank, exp_prg(int'(cpu_addr[14])));
         chk("rnd_chr", chr_bank, exp_chr(int'(ppu_addr[12])));
         chk("rnd_a10", ciram_a10, exp_a10(int'(ppu_addr[10]), int'(ppu_addr[11])));
         chk("rnd_ctrl", ctrl_q, int'(m_ctrl));
         chk("rnd_ram", prg_ram_en, ((m_prg / 16) % 2 == 0) ? 1 : 0);
         rst      = ($urandom_range(0, 99) == 0);
         romsel   = ($urandom_range(0, 3) != 0);
         cpu_rw   = ($urandom_range(0, 3) == 0);
         m2       = ($urandom_range(0, 5) != 0);
         cpu_addr = 15'($urandom);
         cpu_data = ($urandom_range(0, 11) == 0) ? 8'h80 : 8'($urandom_range(0, 127));
         ppu_addr = 14'($urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
